negate_arbiter: RTL
===================

NEGATE_ARBITER -- requirements
Module: negate_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 8, operand width in bits.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-requester operand valid.
REQ-007 req_data  input  NUM_REQ*WIDTH  packed operands; requester i at bits [i*WIDTH +: WIDTH].
REQ-008 req_ready  output  NUM_REQ  one-hot grant/accept; at most one bit set per cycle.
REQ-009 out_valid  output  1  result register holds a valid result.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_data  output  WIDTH  two's complement negation of the accepted operand.
REQ-012 out_id  output  $clog2(NUM_REQ)  index of the requester that produced out_data.
REQ-013 out_ovf  output  1  set when the operand was the most negative value (e.g. 8'h80).

Function
REQ-014 SHALL implement a two-state FSM: EMPTY (no result held) and FULL (result held, out_valid=1).
REQ-015 An operand SHALL be accepted when req_valid[i] && req_ready[i]; req_ready SHALL be nonzero only if the FSM is EMPTY, or FULL with out_ready=1.
REQ-016 A grant SHALL be round-robin: the search starts at last_grant+1 modulo NUM_REQ; the first requester with req_valid set wins.
REQ-017 last_grant SHALL update only on an accepted operand.
REQ-018 req_ready SHALL be combinational from req_valid, last_grant, FSM state and out_ready, with no combinational path from req_data.
REQ-019 Latency SHALL be one cycle: an operand accepted in cycle N SHALL appear on out_data/out_id/out_ovf with out_valid=1 in cycle N+1.
REQ-020 out_data SHALL equal (~operand + 1) truncated to WIDTH; 0 SHALL map to 0.
REQ-021 out_ovf SHALL be 1 only when operand == {1'b1, {WIDTH-1{1'b0}}}; out_data then equals the operand.
REQ-022 EMPTY->FULL on accept; FULL->EMPTY on out_ready with no new accept; FULL->FULL on a simultaneous drain and accept (back-to-back, full throughput).
REQ-023 In FULL with out_ready=0, out_data/out_id/out_ovf SHALL hold stable and req_ready SHALL be all-zero.
REQ-024 With no req_valid asserted, no grant SHALL occur and last_grant SHALL hold.
REQ-025 Operands from non-granted requesters SHALL be neither consumed nor lost; requesters hold req_valid until accepted.

Reset
REQ-026 Reset SHALL force the FSM to EMPTY: out_valid=0, out_data=0, out_id=0, out_ovf=0.
REQ-027 Reset SHALL set last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-028 Reset asserted mid-operation SHALL discard any held result; no accept SHALL occur in a reset cycle (req_ready=0).

Configuration
REQ-029 Macro NEG_ARB_STATS_EN, when defined, SHALL add output ovf_count (8 bits), a saturating count of accepted overflow operands cleared by rst.
REQ-030 Without NEG_ARB_STATS_EN, the ovf_count port and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-031 Package neg_arb_pkg SHALL hold the FSM state typedef (EMPTY, FULL) and the default NUM_REQ/WIDTH constants.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector, last_grant; output: one-hot grant).
REQ-033 The negation SHALL reuse the existing twos_complement module as the combinational datapath, instantiated once (WIDTH=8).

Verification
REQ-034 Single request: req_valid=4'b0001, data0=8'h05, out_ready=1 -> next cycle out_valid=1, out_data=8'hFB, out_id=0, out_ovf=0.
REQ-035 Round-robin: all four valid continuously with out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; out_valid held high.
REQ-036 Backpressure: result 8'hFF->8'h01 held with out_ready=0 for 3 cycles -> outputs stable, req_ready=0; release -> drain plus next accept in the same cycle.
REQ-037 Boundaries: operands 8'h00, 8'h7F, 8'h80 -> 8'h00/ovf0, 8'h81/ovf0, 8'h80/ovf1; with NEG_ARB_STATS_EN ovf_count=1.
REQ-038 Reset mid-operation: rst in FULL -> next cycle out_valid=0, outputs 0; after release, requester 0 wins over requester 2 when both are valid.

Source files
------------

// File: rtl/neg_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : neg_arb_pkg
// Brief  : Shared types and default sizing for the negate arbiter slice.
// Rev    : 1.0 - initial release
// ============================================================================
package neg_arb_pkg;

    localparam int c_DEF_NUM_REQ = 4;
    localparam int c_DEF_WIDTH   = 8;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Round-robin one-hot grant; search starts one past the last grant.
// Rev    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDW-1:0]     i_last_grant,
    output logic [NUM_REQ-1:0] o_grant
);

    logic           w_found;
    logic [IDW:0]   w_sum;
    logic [IDW-1:0] w_idx;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            // One spare bit so the wrap-around compare works for NUM_REQ = 2**IDW.
            w_sum = {1'b0, i_last_grant} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDW+1)'(NUM_REQ);
            end
            w_idx = w_sum[IDW-1:0];
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/twos_complement.sv
`default_nettype none
// ============================================================================
// Module : twos_complement
// Brief  : Combinational two's complement negation with most-negative flag.
// Rev    : 1.0 - initial release
// ============================================================================
module twos_complement #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_operand,
    output logic [WIDTH-1:0] o_result,
    output logic             o_ovf
);

    // The most negative value has no positive counterpart and negates to itself.
    assign o_result = ~i_operand + {{(WIDTH-1){1'b0}}, 1'b1};
    assign o_ovf    = (i_operand == {1'b1, {(WIDTH-1){1'b0}}});

endmodule
`default_nettype wire

// File: rtl/negate_arbiter.sv
`default_nettype none
// ============================================================================
// Module : negate_arbiter
// Brief  : Round-robin arbiter feeding a registered two's complement negator.
//          Define NEG_ARB_STATS_EN to add the ovf_count saturating counter.
// Rev    : 1.0 - initial release
// ============================================================================
module negate_arbiter
    import neg_arb_pkg::*;
#(
    parameter int NUM_REQ = c_DEF_NUM_REQ,
    parameter int WIDTH   = c_DEF_WIDTH,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [IDW-1:0]           out_id,
    output logic                     out_ovf
`ifdef NEG_ARB_STATS_EN
    ,
    output logic [7:0]               ovf_count
`endif
);

    state_t           r_state;
    state_t           w_state_next;
    logic [IDW-1:0]   r_last_grant;
    logic [WIDTH-1:0] r_data;
    logic [IDW-1:0]   r_id;
    logic             r_ovf;

    logic [NUM_REQ-1:0] w_grant;
    logic               w_can_accept;
    logic               w_accept;
    logic [IDW-1:0]     w_sel_id;
    logic [IDW-1:0]     w_k;
    logic [WIDTH-1:0]   w_ops [NUM_REQ];
    logic [WIDTH-1:0]   w_operand;
    logic [WIDTH-1:0]   w_neg;
    logic               w_ovf;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    // Ready never depends on req_data; reset blocks any accept in its cycle.
    assign w_can_accept = !rst && ((r_state == EMPTY) || out_ready);
    assign req_ready    = w_can_accept ? w_grant : '0;
    assign w_accept     = |(req_valid & req_ready);

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_ops[i] = req_data[i*WIDTH +: WIDTH];
    end

    always_comb begin
        w_sel_id = '0;
        w_k      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_k = IDW'(k);
            if (req_ready[w_k]) begin
                w_sel_id = w_k;
            end
        end
    end

    assign w_operand = w_ops[w_sel_id];

    twos_complement #(
        .WIDTH (WIDTH)
    ) u_neg (
        .i_operand (w_operand),
        .o_result  (w_neg),
        .o_ovf     (w_ovf)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            EMPTY:   if (w_accept) w_state_next = FULL;
            FULL:    if (out_ready && !w_accept) w_state_next = EMPTY;
            default: w_state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= EMPTY;
            r_last_grant <= IDW'(NUM_REQ - 1);
            r_data       <= '0;
            r_id         <= '0;
            r_ovf        <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_last_grant <= w_sel_id;
                r_data       <= w_neg;
                r_id         <= w_sel_id;
                r_ovf        <= w_ovf;
            end
        end
    end

    assign out_valid = (r_state == FULL);
    assign out_data  = r_data;
    assign out_id    = r_id;
    assign out_ovf   = r_ovf;

`ifdef NEG_ARB_STATS_EN
    logic [7:0] r_ovf_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_count <= '0;
        end else if (w_accept && w_ovf && (r_ovf_count != 8'hFF)) begin
            r_ovf_count <= r_ovf_count + 8'd1;
        end
    end

    assign ovf_count = r_ovf_count;
`endif

endmodule
`default_nettype wire
